// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the RICS memory-access stage: FSM state encoding,
// default widths/latency and the load-countdown width helper.
package mem_access_stage_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 8;
  localparam int REG_AW_DEF   = 3;
  localparam int LOAD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Bits needed to hold the load countdown value LOAD_LAT-1 (at least one bit).
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Single-port synchronous data RAM, 2**ADDR_W x DATA_W, word addressed.
// Reads land in a one-cycle output register that holds until the next read.
// Contents are deliberately not reset.
module mem_access_stage_data_mem
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit RICS pipeline: word loads/stores on an internal
// data RAM with configurable load latency, valid/ready handoff to write-back.
// Optional feature macro: MEM_ADDR_CHECK_EN (adds out_addrErr, blocks accesses
// whose address has non-zero bits above ADDR_W; otherwise those bits alias).
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF
) (
  input  logic              inp_clk,
  input  logic              inp_rstn,
  input  logic              inp_valid,
  output logic              out_ready,
  input  logic [DATA_W-1:0] inp_aluResult,
  input  logic [DATA_W-1:0] inp_data2,
  input  logic              inp_memRead,
  input  logic              inp_memWrite,
  input  logic              inp_regWrite,
  input  logic [REG_AW-1:0] inp_writeReg,
  output logic              out_valid,
  input  logic              inp_ready,
  output logic [DATA_W-1:0] out_wbData,
  output logic              out_regWrite,
  output logic [REG_AW-1:0] out_writeReg
`ifdef MEM_ADDR_CHECK_EN
  ,output logic             out_addrErr
`endif
);

  localparam int                CNT_W  = cnt_width(LOAD_LAT);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                reg_write_q, reg_write_d;
  logic [REG_AW-1:0]   write_reg_q, write_reg_d;
  logic                err_q, err_d;

  logic                accept;
  logic                addr_err;
  logic                mem_we;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_rdata;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_err = (inp_memRead | inp_memWrite) & (|inp_aluResult[DATA_W-1:ADDR_W]);
  assign out_addrErr = err_q & (state_q == S_OUT);
`else
  assign addr_err = 1'b0;
`endif

  assign out_ready = (state_q == S_IDLE) | ((state_q == S_OUT) & inp_ready);
  assign accept    = inp_valid & out_ready;

  mem_access_stage_data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (inp_clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (inp_aluResult[ADDR_W-1:0]),
    .wdata (inp_data2),
    .rdata (mem_rdata)
  );

  // Next-state, load countdown, result capture and RAM strobes; an accept
  // (from idle or on the handoff edge) overrides the per-state defaults.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    reg_write_d = reg_write_q;
    write_reg_d = write_reg_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (cnt_q == '0) begin
          wb_data_d = err_q ? '0 : mem_rdata;
          state_d   = S_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OUT: begin
        if (inp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      reg_write_d = inp_regWrite;
      write_reg_d = inp_writeReg;
      err_d       = addr_err;
      if (inp_memRead) begin
        // A load wins when both read and write are set; no write happens.
        mem_re  = inp_rstn;
        cnt_d   = LAT_M1;
        state_d = S_LOAD;
      end else begin
        // Strobe gated by reset so nothing commits on a reset edge.
        mem_we    = inp_memWrite & ~addr_err & inp_rstn;
        wb_data_d = inp_aluResult;
        state_d   = S_OUT;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wb_data_q   <= '0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      err_q       <= err_d;
    end
  end

  assign out_valid    = (state_q == S_OUT);
  assign out_wbData   = wb_data_q;
  assign out_regWrite = reg_write_q;
  assign out_writeReg = write_reg_q;

endmodule
